// File: rtl/msrv32_imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshake and sideband tag.
// Optional IMM_ZERO_FLAG_EN adds imm_zero_out, registered alongside imm_out.
module msrv32_imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [24:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             illegal_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef IMM_ZERO_FLAG_EN
  ,
  output logic             imm_zero_out
`endif
);

  // Field indices follow the full instruction word (bits [31:7]).
  function automatic logic [XLEN-1:0] decode(input logic [31:7] ins, input logic [2:0] ty);
    logic s;
    s = ins[31];
    case (ty)
      3'b000, 3'b001: decode = {{(XLEN-12){s}}, ins[31:20]};
      3'b010:         decode = {{(XLEN-12){s}}, ins[31:25], ins[11:7]};
      3'b011:         decode = {{(XLEN-12){s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b100:         decode = {{(XLEN-20){s}}, ins[31:12]} << 12;
      3'b101:         decode = {{(XLEN-20){s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b110:         decode = {{(XLEN-5){1'b0}}, ins[19:15]};
      default:        decode = '0;
    endcase
  endfunction

  logic             out_ready;
  logic             src_valid;
  logic [31:7]      src_instr;
  logic [2:0]       src_type;
  logic [TAG_W-1:0] src_tag;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;

  assign out_ready = !valid_out || ready_in;

  if (PIPE_STAGES == 2) begin : g_two_stage
    logic             s1_valid_q;
    logic [31:7]      s1_instr_q;
    logic [2:0]       s1_type_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             in_xfer;

    assign ready_out = !s1_valid_q || out_ready;
    assign in_xfer   = valid_in && ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        s1_valid_q <= 1'b0;
      end else if (in_xfer) begin
        s1_valid_q <= 1'b1;
      end else if (out_ready) begin
        s1_valid_q <= 1'b0;
      end
    end

    // Raw fields only move on a real transfer so X on idle inputs never lands here.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        s1_instr_q <= '0;
        s1_type_q  <= '0;
        s1_tag_q   <= '0;
      end else if (in_xfer) begin
        s1_instr_q <= instr_in;
        s1_type_q  <= imm_type_in;
        s1_tag_q   <= tag_in;
      end
    end

    assign src_valid = s1_valid_q;
    assign src_instr = s1_instr_q;
    assign src_type  = s1_type_q;
    assign src_tag   = s1_tag_q;
  end else begin : g_one_stage
    assign ready_out = out_ready;
    assign src_valid = valid_in;
    assign src_instr = instr_in;
    assign src_type  = imm_type_in;
    assign src_tag   = tag_in;
  end

  assign dec_imm     = decode(src_instr, src_type);
  assign dec_illegal = (src_type == 3'b111);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
    end else if (out_ready) begin
      valid_out <= src_valid;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      imm_out     <= '0;
      tag_out     <= '0;
      illegal_out <= 1'b0;
    end else if (src_valid && out_ready) begin
      imm_out     <= dec_imm;
      tag_out     <= src_tag;
      illegal_out <= dec_illegal;
    end
  end

`ifdef IMM_ZERO_FLAG_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      imm_zero_out <= 1'b0;
    end else if (src_valid && out_ready) begin
      imm_zero_out <= (dec_imm == '0);
    end
  end
`endif

endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
// Bench for msrv32_imm_gen_pipe: XLEN=32/PIPE_STAGES=1 and XLEN=64/PIPE_STAGES=2 instances,
// table vectors, stall and reset sequences, and randomized traffic against a scoreboard.
module tb_msrv32_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] a_instr, b_instr;
  logic [2:0]  a_type, b_type;
  logic [4:0]  a_tag, b_tag, a_tag_out, b_tag_out;
  logic        a_valid_in, a_ready_out, a_ready_in, a_valid_out, a_ill;
  logic        b_valid_in, b_ready_out, b_ready_in, b_valid_out, b_ill;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
`ifdef IMM_ZERO_FLAG_EN
  logic a_zero, b_zero;
`endif

  msrv32_imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .instr_in(a_instr[31:7]), .imm_type_in(a_type),
    .tag_in(a_tag), .valid_in(a_valid_in), .ready_out(a_ready_out), .imm_out(a_imm),
    .tag_out(a_tag_out), .illegal_out(a_ill), .valid_out(a_valid_out), .ready_in(a_ready_in)
`ifdef IMM_ZERO_FLAG_EN
    , .imm_zero_out(a_zero)
`endif
  );

  msrv32_imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(2), .TAG_W(5)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .instr_in(b_instr[31:7]), .imm_type_in(b_type),
    .tag_in(b_tag), .valid_in(b_valid_in), .ready_out(b_ready_out), .imm_out(b_imm),
    .tag_out(b_tag_out), .illegal_out(b_ill), .valid_out(b_valid_out), .ready_in(b_ready_in)
`ifdef IMM_ZERO_FLAG_EN
    , .imm_zero_out(b_zero)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate from arithmetic shifts of the sign-extended instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] ty);
    longint v, hi;
    logic [63:0] r;
    v = $signed(ins);
    r = 64'd0;
    case (ty)
      3'd0, 3'd1: begin hi = v >>> 20; r = hi; end
      3'd2: begin hi = v >>> 25; r = (hi << 5) | 64'(ins[11:7]); end
      3'd3: begin
        hi = v >>> 31;
        r = (hi << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      3'd4: begin hi = v >>> 12; r = hi << 12; end
      3'd5: begin
        hi = v >>> 31;
        r = (hi << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      3'd6: r = 64'(ins[19:15]);
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  int   a_in_cnt = 0, a_out_cnt = 0, b_in_cnt = 0, b_out_cnt = 0;
  logic a_prev_stall = 1'b0, b_prev_stall = 1'b0;
  exp_t a_prev, b_prev;

  always @(posedge clk or negedge rst_n) begin : mon_a
    exp_t e;
    if (!rst_n) begin
      a_q.delete();
      a_prev_stall = 1'b0;
      a_in_cnt = 0;
      a_out_cnt = 0;
    end else begin
      if (a_prev_stall) begin
        check("a_hold_valid", 64'(a_valid_out), 64'd1);
        check("a_hold_imm", 64'(a_imm), a_prev.imm);
        check("a_hold_tag", 64'(a_tag_out), 64'(a_prev.tag));
      end
      if (a_valid_out && a_ready_in) begin
        a_out_cnt++;
        if (a_q.size() == 0) begin
          check("a_out_without_input", 64'(a_q.size()), 64'd1);
        end else begin
          e = a_q.pop_front();
          check("a_sb_imm", 64'(a_imm), 64'(e.imm[31:0]));
          check("a_sb_tag", 64'(a_tag_out), 64'(e.tag));
          check("a_sb_ill", 64'(a_ill), 64'(e.ill));
`ifdef IMM_ZERO_FLAG_EN
          check("a_sb_zero", 64'(a_zero), 64'(e.imm[31:0] == 32'd0));
`endif
        end
      end
      a_prev_stall = a_valid_out && !a_ready_in;
      a_prev = {64'(a_imm), a_tag_out, a_ill};
      if (a_valid_in && a_ready_out) begin
        a_q.push_back({ref_imm(a_instr, a_type), a_tag, (a_type == 3'b111)});
        a_in_cnt++;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin : mon_b
    exp_t e;
    if (!rst_n) begin
      b_q.delete();
      b_prev_stall = 1'b0;
      b_in_cnt = 0;
      b_out_cnt = 0;
    end else begin
      if (b_prev_stall) begin
        check("b_hold_valid", 64'(b_valid_out), 64'd1);
        check("b_hold_imm", b_imm, b_prev.imm);
        check("b_hold_tag", 64'(b_tag_out), 64'(b_prev.tag));
      end
      if (b_valid_out && b_ready_in) begin
        b_out_cnt++;
        if (b_q.size() == 0) begin
          check("b_out_without_input", 64'(b_q.size()), 64'd1);
        end else begin
          e = b_q.pop_front();
          check("b_sb_imm", b_imm, e.imm);
          check("b_sb_tag", 64'(b_tag_out), 64'(e.tag));
          check("b_sb_ill", 64'(b_ill), 64'(e.ill));
`ifdef IMM_ZERO_FLAG_EN
          check("b_sb_zero", 64'(b_zero), 64'(e.imm == 64'd0));
`endif
        end
      end
      b_prev_stall = b_valid_out && !b_ready_in;
      b_prev = {b_imm, b_tag_out, b_ill};
      if (b_valid_in && b_ready_out) begin
        b_q.push_back({ref_imm(b_instr, b_type), b_tag, (b_type == 3'b111)});
        b_in_cnt++;
      end
    end
  end

  // Holds one request on b until accepted, with a bounded wait.
  task automatic send_b(input logic [31:0] ins, input logic [2:0] ty, input logic [4:0] tg);
    int   waits;
    logic acc;
    waits = 0;
    b_valid_in = 1'b1;
    b_instr = ins;
    b_type = ty;
    b_tag = tg;
    do begin
      #3;
      acc = b_ready_out;
      @(posedge clk);
      #1;
      waits++;
    end while (!acc && waits < 20);
    if (!acc) check("b_send_timeout", 64'(acc), 64'd1);
    b_valid_in = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  ty;
    logic [4:0]  tag;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  logic [63:0] saved_imm;
  logic [4:0]  saved_tag;
  logic [31:0] req_instr[4];
  logic [2:0]  req_type[4];
  logic        a_acc, b_acc;

  initial begin
    vecs[0] = '{32'hFFF00093, 3'd0, 5'd3,  64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'h0020A423, 3'd2, 5'd4,  64'h0000000000000008, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'd3, 5'd5,  64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3] = '{32'h123450B7, 3'd4, 5'd6,  64'h0000000012345000, 1'b0};
    vecs[4] = '{32'h0080006F, 3'd5, 5'd7,  64'h0000000000000008, 1'b0};
    vecs[5] = '{32'h000F8073, 3'd6, 5'd8,  64'h000000000000001F, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 3'd7, 5'd9,  64'h0000000000000000, 1'b1};
    vecs[7] = '{32'h800000B7, 3'd4, 5'd10, 64'hFFFFFFFF80000000, 1'b0};
    vecs[8] = '{32'h7FF00013, 3'd1, 5'd11, 64'h00000000000007FF, 1'b0};
    vecs[9] = '{32'hFFDFF06F, 3'd5, 5'd31, 64'hFFFFFFFFFFFFFFFC, 1'b0};

    rst_n = 1'b0;
    a_instr = '0; a_type = '0; a_tag = '0; a_valid_in = 1'b0; a_ready_in = 1'b1;
    b_instr = '0; b_type = '0; b_tag = '0; b_valid_in = 1'b0; b_ready_in = 1'b1;
    #1;
    check("rst_a_valid", 64'(a_valid_out), 64'd0);
    check("rst_a_imm", 64'(a_imm), 64'd0);
    check("rst_a_tag", 64'(a_tag_out), 64'd0);
    check("rst_a_ill", 64'(a_ill), 64'd0);
    check("rst_a_ready", 64'(a_ready_out), 64'd1);
    check("rst_b_valid", 64'(b_valid_out), 64'd0);
    check("rst_b_ready", 64'(b_ready_out), 64'd1);
`ifdef IMM_ZERO_FLAG_EN
    check("rst_a_zero", 64'(a_zero), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream through the single-stage instance.
    for (int i = 0; i < NV; i++) begin
      a_valid_in = 1'b1;
      a_instr = vecs[i].instr;
      a_type = vecs[i].ty;
      a_tag = vecs[i].tag;
      #3;
      check("a_tbl_ready", 64'(a_ready_out), 64'd1);
      @(posedge clk);
      #1;
      check("a_tbl_valid", 64'(a_valid_out), 64'd1);
      check("a_tbl_imm", 64'(a_imm), 64'(vecs[i].exp[31:0]));
      check("a_tbl_tag", 64'(a_tag_out), 64'(vecs[i].tag));
      check("a_tbl_ill", 64'(a_ill), 64'(vecs[i].ill));
    end
    a_valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("a_tbl_drained", 64'(a_valid_out), 64'd0);

    // Same stream through the two-stage XLEN=64 instance.
    for (int i = 0; i <= NV; i++) begin
      b_valid_in = (i < NV);
      if (i < NV) begin
        b_instr = vecs[i].instr;
        b_type = vecs[i].ty;
        b_tag = vecs[i].tag;
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        check("b_tbl_valid", 64'(b_valid_out), 64'd1);
        check("b_tbl_imm", b_imm, vecs[i-1].exp);
        check("b_tbl_tag", 64'(b_tag_out), 64'(vecs[i-1].tag));
        check("b_tbl_ill", 64'(b_ill), 64'(vecs[i-1].ill));
      end
    end
    b_valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("b_tbl_drained", 64'(b_valid_out), 64'd0);

    // Stall: two entries fill the pipe, output held while ready_in is low.
    for (int k = 0; k < 4; k++) begin
      req_instr[k] = $urandom;
      req_type[k] = 3'($urandom_range(0, 6));
    end
    b_ready_in = 1'b0;
    send_b(req_instr[0], req_type[0], 5'd20);
    send_b(req_instr[1], req_type[1], 5'd21);
    check("stall_ready_low", 64'(b_ready_out), 64'd0);
    check("stall_valid", 64'(b_valid_out), 64'd1);
    check("stall_first_imm", b_imm, ref_imm(req_instr[0], req_type[0]));
    saved_imm = b_imm;
    saved_tag = b_tag_out;
    b_valid_in = 1'b1;
    b_instr = req_instr[2];
    b_type = req_type[2];
    b_tag = 5'd22;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("stall_imm_stable", b_imm, saved_imm);
      check("stall_tag_stable", 64'(b_tag_out), 64'(saved_tag));
      check("stall_ready_still_low", 64'(b_ready_out), 64'd0);
    end
    b_ready_in = 1'b1;
    send_b(req_instr[2], req_type[2], 5'd22);
    send_b(req_instr[3], req_type[3], 5'd23);
    repeat (4) @(posedge clk);
    #1;
    check("stall_count_match", 64'(b_out_cnt), 64'(b_in_cnt));
    check("stall_queue_empty", 64'(b_q.size()), 64'd0);

    // Reset with two entries in flight.
    b_ready_in = 1'b0;
    send_b(32'h12345093, 3'd0, 5'd1);
    send_b(32'h876540B7, 3'd4, 5'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(b_valid_out), 64'd0);
    check("rst_mid_ready", 64'(b_ready_out), 64'd1);
    check("rst_mid_imm", b_imm, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    b_ready_in = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", 64'(b_valid_out), 64'd0);
    end

    // Randomized traffic with random backpressure on both instances.
    a_acc = 1'b0;
    b_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_valid_in || a_acc) begin
        a_valid_in = ($urandom_range(0, 9) < 7);
        a_instr = $urandom;
        a_type = 3'($urandom_range(0, 7));
        a_tag = 5'($urandom);
      end
      if (!b_valid_in || b_acc) begin
        b_valid_in = ($urandom_range(0, 9) < 7);
        b_instr = $urandom;
        b_type = 3'($urandom_range(0, 7));
        b_tag = 5'($urandom);
      end
      a_ready_in = ($urandom_range(0, 3) != 0);
      b_ready_in = ($urandom_range(0, 3) != 0);
      #3;
      a_acc = a_valid_in && a_ready_out;
      b_acc = b_valid_in && b_ready_out;
      @(posedge clk);
      #1;
    end
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    a_ready_in = 1'b1;
    b_ready_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rnd_a_count", 64'(a_out_cnt), 64'(a_in_cnt));
    check("rnd_b_count", 64'(b_out_cnt), 64'(b_in_cnt));
    check("rnd_a_progress", 64'(a_in_cnt > 100), 64'd1);
    check("rnd_b_progress", 64'(b_in_cnt > 100), 64'd1);
    check("rnd_a_empty", 64'(a_q.size()), 64'd0);
    check("rnd_b_empty", 64'(b_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
